// File: rtl/i2c_slave_responder.sv
// I2C target at a fixed 7-bit address serving an auto-incrementing byte bank (write, read, combined).
// Bus events act 3 clocks after the pins; no backpressure (no clock stretching), sda is only ever pulled low.
module i2c_slave_responder #(
   parameter int         DATA_SIZE  = 8,
   parameter int         PTR_SIZE   = 3,
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic                 i2c_core_clk_i,
   input  logic                 reset_ni,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 sda_oe_o,
   output logic                 busy_o,
   output logic                 wr_strobe_o,
   output logic [PTR_SIZE-1:0]  wr_ptr_o,
   output logic [DATA_SIZE-1:0] wr_data_o,
   output logic                 stop_o,
   input  logic [PTR_SIZE-1:0]  dbg_ptr_i,
   output logic [DATA_SIZE-1:0] dbg_data_o
);

   localparam int DEPTH = 2**PTR_SIZE;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ACK_ADDR, S_WR_PTR, S_WR_DATA, S_RD_BYTE, S_RD_ACK, S_IGNORE
   } state_t;

   state_t               r_state;
   logic [2:0]           r_scl_sh;
   logic [2:0]           r_sda_sh;
   logic [3:0]           r_cnt;
   logic [DATA_SIZE-1:0] r_shift;
   logic [PTR_SIZE-1:0]  r_ptr;
   logic                 r_rw;
   logic                 r_oe;
   logic                 r_busy;
   logic                 r_wr_stb;
   logic [PTR_SIZE-1:0]  r_wr_ptr;
   logic [DATA_SIZE-1:0] r_wr_data;
   logic                 r_stop;
   logic [DATA_SIZE-1:0] r_bank [DEPTH];

   logic                 w_scl;
   logic                 w_scl_d;
   logic                 w_sda;
   logic                 w_sda_d;
   logic                 w_scl_rise;
   logic                 w_scl_fall;
   logic                 w_start;
   logic                 w_stop;
   logic [DATA_SIZE-1:0] w_byte;
   logic [DATA_SIZE-1:0] w_bank_rd;
   logic [PTR_SIZE-1:0]  w_ptr_inc;

   // [0],[1] synchronise; [2] holds the previous synced level for edge detection
   assign w_scl      = r_scl_sh[1];
   assign w_scl_d    = r_scl_sh[2];
   assign w_sda      = r_sda_sh[1];
   assign w_sda_d    = r_sda_sh[2];
   assign w_scl_rise = w_scl & ~w_scl_d;
   assign w_scl_fall = ~w_scl & w_scl_d;
   assign w_start    = w_scl & w_scl_d & w_sda_d & ~w_sda;
   assign w_stop     = w_scl & w_scl_d & ~w_sda_d & w_sda;
   assign w_byte     = {r_shift[DATA_SIZE-2:0], w_sda};
   assign w_bank_rd  = r_bank[r_ptr];
   assign w_ptr_inc  = r_ptr + PTR_SIZE'(1);

   assign sda_oe_o    = r_oe;
   assign busy_o      = r_busy;
   assign wr_strobe_o = r_wr_stb;
   assign wr_ptr_o    = r_wr_ptr;
   assign wr_data_o   = r_wr_data;
   assign stop_o      = r_stop;
   assign dbg_data_o  = r_bank[dbg_ptr_i];

   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         // Lines reset to the idle-high level so release of reset never fakes a bus event
         r_scl_sh  <= 3'b111;
         r_sda_sh  <= 3'b111;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_shift   <= '0;
         r_ptr     <= '0;
         r_rw      <= 1'b0;
         r_oe      <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_stb  <= 1'b0;
         r_wr_ptr  <= '0;
         r_wr_data <= '0;
         r_stop    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
      end else begin
         r_scl_sh <= {r_scl_sh[1:0], scl_i};
         r_sda_sh <= {r_sda_sh[1:0], sda_i};
         r_wr_stb <= 1'b0;
         r_stop   <= 1'b0;
         if (w_stop) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
            r_busy  <= 1'b0;
            r_stop  <= 1'b1;
         end else if (w_start) begin
            r_state <= S_ADDR;
            r_cnt   <= '0;
            r_oe    <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise) begin
                     r_shift <= w_byte;
                     r_cnt   <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7) begin
                        if (w_byte[DATA_SIZE-1:1] == SLAVE_ADDR) begin
                           r_state <= S_ACK_ADDR;
                           r_busy  <= 1'b1;
                           r_rw    <= w_byte[0];
                        end else begin
                           r_state <= S_IGNORE;
                        end
                     end
                  end
               end
               // First fall asserts the ACK, second fall ends it and starts the data phase
               S_ACK_ADDR: begin
                  if (w_scl_fall) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else if (r_rw) begin
                        r_shift <= {w_bank_rd[DATA_SIZE-2:0], 1'b0};
                        r_oe    <= ~w_bank_rd[DATA_SIZE-1];
                        r_cnt   <= 4'd1;
                        r_state <= S_RD_BYTE;
                     end else begin
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WR_PTR;
                     end
                  end
               end
               S_WR_PTR, S_WR_DATA: begin
                  if (w_scl_rise && r_cnt != 4'd8) begin
                     r_shift <= w_byte;
                     r_cnt   <= r_cnt + 4'd1;
                     if (r_cnt == 4'd7) begin
                        if (r_state == S_WR_PTR) begin
                           r_ptr <= w_byte[PTR_SIZE-1:0];
                        end else begin
                           r_bank[r_ptr] <= w_byte;
                           r_wr_stb      <= 1'b1;
                           r_wr_ptr      <= r_ptr;
                           r_wr_data     <= w_byte;
                           r_ptr         <= w_ptr_inc;
                        end
                     end
                  end else if (w_scl_fall && r_cnt == 4'd8) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else begin
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_WR_DATA;
                     end
                  end
               end
               // Bit 7 went out on entry, so seven more falls shift out bits 6..0
               S_RD_BYTE: begin
                  if (w_scl_fall) begin
                     if (r_cnt != 4'd8) begin
                        r_oe    <= ~r_shift[DATA_SIZE-1];
                        r_shift <= {r_shift[DATA_SIZE-2:0], 1'b0};
                        r_cnt   <= r_cnt + 4'd1;
                     end else begin
                        r_oe    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RD_ACK;
                     end
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise && r_cnt == 4'd0) begin
                     if (!w_sda) begin
                        r_ptr <= w_ptr_inc;
                        r_cnt <= 4'd1;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end else if (w_scl_fall && r_cnt == 4'd1) begin
                     r_shift <= {w_bank_rd[DATA_SIZE-2:0], 1'b0};
                     r_oe    <= ~w_bank_rd[DATA_SIZE-1];
                     r_state <= S_RD_BYTE;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
